// File: rtl/alu_pkg.sv
// Opcodes and controller state encoding shared by the registered ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SEXT = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_ANDR = 3'b100;
    localparam logic [2:0] OP_CAT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/rca_n.sv
// N-bit ripple-carry adder assembled from a chain of full-adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);
    logic [N:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (c[i]),
            .s    (s[i]),
            .c_out(c[i+1])
        );
    end

    assign c_out = c[N];
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with Start/Busy/Done handshake; ALUout doubles as accumulator,
// multiply runs shift-add over N cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N   = 4,
    parameter int SHW = $clog2(2*N)
) (
    input  logic           Clock,
    input  logic           Reset_b,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [2:0]     Function,
    input  logic           UseAcc,
    output logic [2*N-1:0] ALUout,
    output logic           Busy,
    output logic           Done
);
    localparam int CW = $clog2(N);

    state_t         state, state_nx;
    logic [2*N-1:0] alu_q, alu_nx;
    logic [2*N-1:0] prod, prod_nx, prod_add;
    logic [2*N-1:0] mcand, mcand_nx;
    logic [N-1:0]   mplier, mplier_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           done_q, done_nx;

    logic [N-1:0]   op_a, sum, diff;
    logic           carry;
    logic [2*N-1:0] res;

    assign op_a = UseAcc ? alu_q[N-1:0] : A;
    assign diff = op_a - B;

    rca_n #(.N(N)) u_rca (
        .a    (op_a),
        .b    (B),
        .c_in (1'b0),
        .s    (sum),
        .c_out(carry)
    );

    // Result of every single-cycle opcode, evaluated from the live inputs
    always_comb begin
        res = '0;
        case (Function)
            OP_ADD:  res = {{(N-1){1'b0}}, carry, sum};
            OP_SUB:  res = {{N{diff[N-1]}}, diff};
            OP_SEXT: res = {{N{B[N-1]}}, B};
            OP_ORR:  res = {{(2*N-1){1'b0}}, |{op_a, B}};
            OP_ANDR: res = {{(2*N-1){1'b0}}, &{op_a, B}};
            OP_CAT:  res = {op_a, B};
            OP_SHL:  res = {{N{1'b0}}, op_a} << B[SHW-1:0];
            default: res = '0;
        endcase
    end

    assign prod_add = prod + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nx  = state;
        alu_nx    = alu_q;
        prod_nx   = prod;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        cnt_nx    = cnt;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Function == OP_MUL) begin
                        prod_nx   = '0;
                        mcand_nx  = {{N{1'b0}}, op_a};
                        mplier_nx = B;
                        cnt_nx    = '0;
                        state_nx  = MUL;
                    end else begin
                        alu_nx  = res;
                        done_nx = 1'b1;
                    end
                end
            end
            MUL: begin
                prod_nx   = prod_add;
                mcand_nx  = mcand << 1;
                mplier_nx = mplier >> 1;
                cnt_nx    = cnt + 1'b1;
                // Last iteration writes the product straight into ALUout
                if (cnt == CW'(N-1)) begin
                    alu_nx   = prod_add;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state  <= IDLE;
            alu_q  <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            alu_q  <= alu_nx;
            prod   <= prod_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
        end
    end

    assign ALUout = alu_q;
    assign Busy   = (state == MUL);
    assign Done   = done_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Operand width N is generic and the result is 2N bits, held in an output register that doubles as an accumulator.
- Adds a Start/Busy/Done handshake, accumulator feedback, subtraction, shift, and a multi-cycle shift-add multiply.
- Sits between the operand switches/registers and the HEX display/result path of the lab datapath.

Parameters:
- N, default 4: operand width in bits; ALUout width is 2N; N >= 2.
- SHW, default $clog2(2N): width of the shift-amount field taken from B[SHW-1:0].

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_b  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled on the rising edge only while idle.
- A  in  N  operand A.
- B  in  N  operand B.
- Function  in  3  operation select; sampled with Start.
- UseAcc  in  1  when 1, operand A is replaced by ALUout[N-1:0] at the Start edge.
- ALUout  out  2N  registered result / accumulator.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse, high in the cycle after the result is written.

Behaviour:
- Reset: Reset_b=0 immediately forces ALUout=0, Busy=0, Done=0 and state=IDLE, whatever the current state (including mid-multiply). A multiply in flight is discarded.
- States: IDLE and MUL.
- Operand capture: on the edge where state=IDLE and Start=1, capture opA (A, or ALUout[N-1:0] if UseAcc=1), opB=B and Function.
- Operations, all results 2N bits:
  - 000: ripple-carry add; ALUout={ (N-1) zeros, carry_out, sum[N-1:0] }.
  - 001: opA - opB in two's complement, sign-extended to 2N.
  - 010: sign extension of opB to 2N.
  - 011: ALUout = 1 if any bit of {opA,opB} is 1, else 0.
  - 100: ALUout = 1 if all bits of {opA,opB} are 1, else 0.
  - 101: ALUout = {opA, opB}.
  - 110: unsigned opA*opB by shift-add, one bit of opB per cycle, LSB first.
  - 111: zero-extended opA logically shifted left by opB[SHW-1:0]; bits shifted past bit 2N-1 are lost.
- Single-cycle ops (all except 110): ALUout is written on the capture edge. Done=1 for the following cycle only. Busy stays 0. Latency is 1 cycle.
- Multiply (110):
  - Capture edge: clear the internal product, load the multiplicand and multiplier, enter MUL, Busy=1.
  - N further edges each perform one iteration.
  - The edge ending the Nth MUL cycle writes ALUout with the product, returns to IDLE, sets Busy=0 and raises Done for one cycle.
  - Latency is N+1 edges. ALUout holds its previous value throughout MUL.
- Start while Busy=1 is ignored and not queued. Start in the Done cycle (IDLE) is accepted normally.
- A, B, Function and UseAcc changing during MUL have no effect.
- Start held high in IDLE issues a new operation every cycle (back-to-back single-cycle ops, Done stays high).
- Arithmetic wraps modulo 2^(2N). No overflow flag.

Decomposition:
- Package alu_pkg: 3-bit opcode localparams (OP_ADD, OP_SUB, OP_SEXT, OP_ORR, OP_ANDR, OP_CAT, OP_MUL, OP_SHL) and the state encoding (IDLE, MUL).
- Sub-module rca_n (parameter N): generate-loop ripple-carry adder of full_adder cells with inputs a, b, c_in and outputs s, c_out. Used for OP_ADD.
- OP_MUL accumulation uses '+' on 2N-bit values.

Test Plan (N=4):
1. Assert Reset_b=0 with inputs random -> ALUout=8'h00, Busy=0, Done=0; release -> outputs unchanged.
2. Start, Function=000, A=4'hF, B=4'h1 -> after 1 edge ALUout=8'h10, Done=1 for exactly 1 cycle, Busy=0 throughout.
3. Start, 000, A=2, B=3 -> ALUout=8'h05; then Start, 000, UseAcc=1, A=4'hF, B=4 -> ALUout=8'h09 (A ignored).
4. Start, 110, A=4'hF, B=4'hD -> Busy=1 for 4 cycles, ALUout stays old value, then ALUout=8'hC3 and Done pulses; Start with 000 pulsed during Busy -> ignored.
5. Single-cycle sweep:
   - 001, A=2, B=5 -> 8'hFD
   - 010, B=4'h9 -> 8'hF9
   - 011, A=0, B=0 -> 8'h00
   - 100, A=4'hF, B=4'hF -> 8'h01
   - 101, A=4'hA, B=4'h5 -> 8'hA5
   - 111, A=3, B=5 -> 8'h60
   - 111, A=1, B=4'hB -> 8'h08 (shift amount 3, SHW=3)
6. Start 110 (A=7, B=7), assert Reset_b=0 in the 2nd MUL cycle -> immediate ALUout=0, Busy=0, Done=0; release, Start 000 with A=1, B=1 -> ALUout=8'h02 after 1 edge.
